// File: rtl/vend_credit_ctrl.sv
// rtl/vend_credit_ctrl.sv - vending credit accumulator with dispense/refund sequencer
// Optional build macro AUTO_VEND_EN: vend automatically once credit reaches PRICE.
module vend_credit_ctrl #(
   parameter int CW              = 4,
   parameter int MAX_CREDIT      = 8,
   parameter int PRICE           = 5,
   parameter int DISPENSE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          coin1,
   input  logic          coin2,
   input  logic          buy,
   input  logic          cancel,
   output logic [CW-1:0] credit,
   output logic          tomato_ok,
   output logic          dispense,
   output logic          refund,
   output logic          coin_reject,
   output logic          buy_deny,
   output logic          busy
);

   localparam int DW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
   localparam logic [DW-1:0] DC_LAST = DW'(DISPENSE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISPENSE,
      ST_REFUND
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_credit, w_credit_nxt;
   logic [DW-1:0]   r_dcnt, w_dcnt_nxt;
   logic            r_coin_reject, w_coin_reject_nxt;
   logic            r_buy_deny, w_buy_deny_nxt;
   logic            w_coin;
   logic            w_can_vend;
   logic            w_auto_vend;
   logic [CW:0]     w_sum;

   assign w_coin     = coin1 | coin2;
   // {coin2,coin1} read as a 2-bit number is exactly coin1 + 2*coin2
   assign w_sum      = {1'b0, r_credit} + {{(CW-1){1'b0}}, coin2, coin1};
   assign w_can_vend = (r_credit >= CW'(PRICE));

`ifdef AUTO_VEND_EN
   assign w_auto_vend = w_can_vend;
`else
   assign w_auto_vend = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_credit      <= '0;
         r_dcnt        <= '0;
         r_coin_reject <= 1'b0;
         r_buy_deny    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_credit      <= w_credit_nxt;
         r_dcnt        <= w_dcnt_nxt;
         r_coin_reject <= w_coin_reject_nxt;
         r_buy_deny    <= w_buy_deny_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_credit_nxt      = r_credit;
      w_dcnt_nxt        = r_dcnt;
      w_coin_reject_nxt = 1'b0;
      w_buy_deny_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cancel && (r_credit != '0)) begin
               w_state_nxt       = ST_REFUND;
               w_coin_reject_nxt = w_coin;
            end else if (w_can_vend && (buy || w_auto_vend)) begin
               w_state_nxt       = ST_DISPENSE;
               w_credit_nxt      = r_credit - CW'(PRICE);
               w_dcnt_nxt        = '0;
               w_coin_reject_nxt = w_coin;
            end else begin
               // Reaching here with buy set means credit is short of PRICE
               w_buy_deny_nxt = buy;
               if (w_coin) begin
                  if (w_sum <= (CW+1)'(MAX_CREDIT))
                     w_credit_nxt = w_sum[CW-1:0];
                  else
                     w_coin_reject_nxt = 1'b1;
               end
            end
         end
         ST_DISPENSE: begin
            w_coin_reject_nxt = w_coin;
            if (r_dcnt == DC_LAST)
               w_state_nxt = ST_IDLE;
            else
               w_dcnt_nxt = r_dcnt + DW'(1);
         end
         ST_REFUND: begin
            w_coin_reject_nxt = w_coin;
            w_credit_nxt      = (r_credit == '0) ? '0 : r_credit - CW'(1);
            if (r_credit <= CW'(1))
               w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign credit      = r_credit;
   assign tomato_ok   = w_can_vend;
   assign dispense    = (r_state == ST_DISPENSE);
   assign refund      = (r_state == ST_REFUND);
   assign coin_reject = r_coin_reject;
   assign buy_deny    = r_buy_deny;
   assign busy        = (r_state != ST_IDLE);

endmodule
